sar_search_ctrl: RTL and testbench

//  Sequential successive-approximation controller: the driving end of a CmpGE-style

---
 rtl/sar_search_ctrl.sv | 136 +++++++++++++
 tb/tb_sar_search_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: successive-approximation search controller.
// Drives a probe word into an external greater-or-equal comparator and
// builds the largest probe for which the comparator answers 1, MSB first,
// spending LAT+1 cycles on each bit so the comparator output can settle.
module sar_search_ctrl #(
  parameter int width = 8,
  parameter int LAT   = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             ready_o,
  input  logic             abort_i,
  output logic [width-1:0] probe_o,
  input  logic             ge_i,
  output logic             valid_o,
  input  logic             res_ack_i,
  output logic [width-1:0] res_o,
  output logic             exact_o
);

  localparam int              BW      = (width > 1) ? $clog2(width) : 1;
  localparam logic [3:0]      LAT_L   = 4'(LAT);
  localparam logic [BW-1:0]   TOP_IDX = BW'(width - 1);
  localparam logic [width-1:0] ONE_W  = width'(1);
  localparam logic [width-1:0] TOP_BIT = ONE_W << (width - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t           r_state, w_stateNext;
  logic [BW-1:0]    r_bitIdx, w_bitIdxNext;
  logic [3:0]       r_cnt, w_cntNext;
  logic [width-1:0] r_acc, w_accNext;
  logic [width-1:0] r_probe, w_probeNext;
  logic             r_allGe, w_allGeNext;
  logic [width-1:0] w_lowerBit;
  logic [width-1:0] w_accSampled;

  // One-hot of the next lower bit position, used to build the following probe.
  assign w_lowerBit   = ONE_W << (r_bitIdx - 1'b1);
  // The current probe already holds acc plus the trial bit, so keeping the
  // trial bit is just adopting the probe value.
  assign w_accSampled = ge_i ? r_probe : r_acc;

  // State and datapath registers; async reset puts everything back to idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_bitIdx <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_probe  <= '0;
      r_allGe  <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_bitIdx <= w_bitIdxNext;
      r_cnt    <= w_cntNext;
      r_acc    <= w_accNext;
      r_probe  <= w_probeNext;
      r_allGe  <= w_allGeNext;
    end
  end

  // Next-state and output logic; ge_i only matters on the last cycle of a slot.
  always_comb begin
    w_stateNext  = r_state;
    w_bitIdxNext = r_bitIdx;
    w_cntNext    = r_cnt;
    w_accNext    = r_acc;
    w_probeNext  = r_probe;
    w_allGeNext  = r_allGe;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    res_o        = '0;
    exact_o      = 1'b0;
    probe_o      = r_probe;

    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          w_stateNext  = S_SEARCH;
          w_bitIdxNext = TOP_IDX;
          w_cntNext    = '0;
          w_accNext    = '0;
          w_probeNext  = TOP_BIT;
          w_allGeNext  = 1'b1;
        end
      end

      S_SEARCH: begin
        if (abort_i) begin
          w_stateNext  = S_IDLE;
          w_bitIdxNext = '0;
          w_cntNext    = '0;
          w_accNext    = '0;
          w_probeNext  = '0;
          w_allGeNext  = 1'b0;
        end else if (r_cnt == LAT_L) begin
          w_accNext   = w_accSampled;
          w_allGeNext = r_allGe & ge_i;
          w_cntNext   = '0;
          if (r_bitIdx == '0) begin
            w_stateNext = S_DONE;
            w_probeNext = '0;
          end else begin
            w_bitIdxNext = r_bitIdx - 1'b1;
            w_probeNext  = w_accSampled | w_lowerBit;
          end
        end else begin
          w_cntNext = r_cnt + 4'd1;
        end
      end

      S_DONE: begin
        valid_o = 1'b1;
        res_o   = r_acc;
        exact_o = r_allGe;
        if (res_ack_i) begin
          w_stateNext = S_IDLE;
          w_accNext   = '0;
          w_allGeNext = 1'b0;
        end
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: directed bench for the SAR search controller.
// Three instances cover the default configuration, a slow comparator and
// the single-bit word; results are predicted by a brute-force model and
// queued at start time, then popped when the DUT raises valid_o.
module tb_sar_search_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       start0, abort0, ack0, ge0;
  logic       ready0, valid0, exact0;
  logic [7:0] probe0, res0;

  logic       startL, abortL, ackL, geL;
  logic       readyL, validL, exactL;
  logic [7:0] probeL, resL;

  logic       start1, abort1, ack1, ge1;
  logic       ready1, valid1, exact1;
  logic [0:0] probe1, res1;

  int mode0 = 0;
  int modeL = 0;

  logic [7:0] dl1 = 8'd0;
  logic [7:0] dl2 = 8'd0;
  logic       noiseBit = 1'b0;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  logic [7:0] expResQ[$];
  logic       expExactQ[$];

  logic [7:0] expProbes[8] = '{8'd128, 8'd64, 8'd96, 8'd112, 8'd104, 8'd100, 8'd102, 8'd101};

  sar_search_ctrl #(.width(8), .LAT(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .ready_o(ready0),
    .abort_i(abort0), .probe_o(probe0), .ge_i(ge0), .valid_o(valid0),
    .res_ack_i(ack0), .res_o(res0), .exact_o(exact0)
  );

  sar_search_ctrl #(.width(8), .LAT(2)) u_dutLat (
    .clk_i(clk), .rst_ni(rst_n), .start_i(startL), .ready_o(readyL),
    .abort_i(abortL), .probe_o(probeL), .ge_i(geL), .valid_o(validL),
    .res_ack_i(ackL), .res_o(resL), .exact_o(exactL)
  );

  sar_search_ctrl #(.width(1), .LAT(0)) u_dutOne (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .ready_o(ready1),
    .abort_i(abort1), .probe_o(probe1), .ge_i(ge1), .valid_o(valid1),
    .res_ack_i(ack1), .res_o(res1), .exact_o(exact1)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Comparator model: 0 threshold 100, 1 always, 2 never, 3 square root of 200.
  function automatic logic geModel(input int mode, input logic [7:0] p);
    case (mode)
      0:       return (p <= 8'd100);
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return ((int'(p) * int'(p)) <= 200);
      default: return 1'b0;
    endcase
  endfunction

  // Largest probe accepted by the model, found by exhaustive search from the top.
  function automatic logic [7:0] expResult(input int mode);
    for (int v = 255; v >= 0; v--) begin
      if (geModel(mode, 8'(v))) return 8'(v);
    end
    return 8'd0;
  endfunction

  // Zero-latency comparator in front of the default instance.
  always_comb ge0 = geModel(mode0, probe0);

  // Two-cycle comparator pipeline for the slow instance, with random noise
  // whenever the pipeline has not yet caught up with the current probe.
  always @(posedge clk) begin
    dl1      <= probeL;
    dl2      <= dl1;
    noiseBit <= 1'($urandom_range(1, 0));
  end

  always_comb geL = (dl2 == probeL) ? geModel(modeL, probeL) : noiseBit;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full search on the default instance: predict, start, wait, compare, acknowledge.
  task automatic applyStimulus(input int mode, input string tag);
    int cycles;
    expResQ.push_back(expResult(mode));
    expExactQ.push_back(expResult(mode) == 8'hFF);
    mode0 = mode;
    checkOutput({tag, " ready before start"}, ready0, 1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cycles = 0;
    while (valid0 !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
    checkOutput({tag, " latency"}, cycles, 8);
    checkOutput({tag, " res"}, res0, expResQ.pop_front());
    checkOutput({tag, " exact"}, exact0, expExactQ.pop_front());
    checkOutput({tag, " probe in done"}, probe0, 0);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    checkOutput({tag, " valid after ack"}, valid0, 0);
    checkOutput({tag, " ready after ack"}, ready0, 1);
  endtask

  // Full search on the slow instance, expecting 24 cycles to a result.
  task automatic runSlow(input int mode, input string tag);
    int cycles;
    expResQ.push_back(expResult(mode));
    expExactQ.push_back(expResult(mode) == 8'hFF);
    modeL = mode;
    startL = 1'b1;
    tick();
    startL = 1'b0;
    cycles = 0;
    while (validL !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    checkOutput({tag, " latency"}, cycles, 24);
    checkOutput({tag, " res"}, resL, expResQ.pop_front());
    checkOutput({tag, " exact"}, exactL, expExactQ.pop_front());
    ackL = 1'b1;
    tick();
    ackL = 1'b0;
    checkOutput({tag, " valid after ack"}, validL, 0);
  endtask

  // Single-bit search: one slot, result equals the sampled flag.
  task automatic runOneBit(input logic geVal, input string tag);
    ge1 = geVal;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checkOutput({tag, " probe"}, probe1, 1);
    tick();
    checkOutput({tag, " valid"}, valid1, 1);
    checkOutput({tag, " res"}, res1, geVal);
    checkOutput({tag, " exact"}, exact1, geVal);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    checkOutput({tag, " ready after ack"}, ready1, 1);
  endtask

  // Directed test sequence.
  initial begin
    int validSeen;
    int unstable;
    logic [7:0] heldRes;

    rst_n = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; ack0 = 1'b0;
    startL = 1'b0; abortL = 1'b0; ackL = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ack1 = 1'b0; ge1 = 1'b0;
    tick();
    tick();
    checkOutput("reset ready", ready0, 1);
    checkOutput("reset valid", valid0, 0);
    checkOutput("reset probe", probe0, 0);
    checkOutput("reset res", res0, 0);
    checkOutput("reset exact", exact0, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] T1 threshold 100, probe sequence");
    mode0 = 0;
    expResQ.push_back(expResult(0));
    expExactQ.push_back(expResult(0) == 8'hFF);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("T1 probe %0d", i), probe0, expProbes[i]);
      if (i == 0) checkOutput("T1 ready in search", ready0, 0);
      tick();
    end
    checkOutput("T1 valid after 8", valid0, 1);
    checkOutput("T1 res", res0, expResQ.pop_front());
    checkOutput("T1 exact", exact0, expExactQ.pop_front());
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    checkOutput("T1 valid after ack", valid0, 0);

    $display("[TB] T2 slow comparator");
    runSlow(0, "T2 thr");
    runSlow(3, "T2 sqrt");

    $display("[TB] T3/T4 constant and sqrt");
    applyStimulus(1, "T3 all ones");
    applyStimulus(2, "T3 all zeros");
    applyStimulus(3, "T4 sqrt");

    $display("[TB] T5 abort");
    start0 = 1'b1;
    abort0 = 1'b1;
    tick();
    start0 = 1'b0;
    abort0 = 1'b0;
    checkOutput("T5 abort ignored in idle", ready0, 0);
    checkOutput("T5 first probe", probe0, 128);
    tick();
    tick();
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    checkOutput("T5 ready after abort", ready0, 1);
    checkOutput("T5 probe after abort", probe0, 0);
    validSeen = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid0 !== 1'b0) validSeen++;
      tick();
    end
    checkOutput("T5 valid never seen", validSeen, 0);
    applyStimulus(0, "T5 rerun");

    $display("[TB] T6 result hold");
    expResQ.push_back(expResult(0));
    expExactQ.push_back(1'b0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    validSeen = 0;
    while (valid0 !== 1'b1 && validSeen < 100) begin
      tick();
      validSeen++;
    end
    checkOutput("T6 latency", validSeen, 8);
    heldRes = res0;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      start0 = 1'b1;
      abort0 = 1'b1;
      tick();
      if (valid0 !== 1'b1 || res0 !== heldRes || ready0 !== 1'b0) unstable++;
    end
    start0 = 1'b0;
    abort0 = 1'b0;
    checkOutput("T6 held stable", unstable, 0);
    checkOutput("T6 res", res0, expResQ.pop_front());
    checkOutput("T6 exact", exact0, expExactQ.pop_front());
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    tick();
    checkOutput("T6 no queued start", ready0, 1);
    checkOutput("T6 idle probe", probe0, 0);

    $display("[TB] T6 async reset mid-search");
    mode0 = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    checkOutput("T6 probe before reset", probe0, 96);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("T6 reset probe", probe0, 0);
    checkOutput("T6 reset valid", valid0, 0);
    checkOutput("T6 reset ready", ready0, 1);
    checkOutput("T6 reset res", res0, 0);
    checkOutput("T6 reset exact", exact0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("T6 idle after reset", ready0, 1);

    $display("[TB] single-bit word");
    runOneBit(1'b1, "W1 ge1");
    runOneBit(1'b0, "W1 ge0");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
